// File: rtl/shift_seq_pkg.sv
// Shared mode codes and controller state encoding for the shift sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_seq_pkg;

    // Single-step shift mode codes
    localparam logic [2:0] SHL0 = 3'b000;  // shift left, fill 0
    localparam logic [2:0] SHL1 = 3'b001;  // shift left, fill 1
    localparam logic [2:0] SHR0 = 3'b010;  // shift right, fill 0
    localparam logic [2:0] SHR1 = 3'b011;  // shift right, fill 1
    localparam logic [2:0] ASL  = 3'b100;  // arithmetic left
    localparam logic [2:0] ASR  = 3'b101;  // arithmetic right
    localparam logic [2:0] ROL  = 3'b110;  // rotate left
    localparam logic [2:0] ROR  = 3'b111;  // rotate right

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage : shift_seq_pkg

// File: rtl/shift_step_unit.sv
// One-bit shift of a 4-bit operand under a 3-bit mode.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module shift_step_unit
    import shift_seq_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [2:0] mode_i,
    output logic [3:0] y_o
);

    // Select the one-step result for the requested mode
    always_comb begin
        y_o = 4'b0000;
        case (mode_i)
            SHL0:    y_o = {a_i[2:0], 1'b0};
            SHL1:    y_o = {a_i[2:0], 1'b1};
            SHR0:    y_o = {1'b0, a_i[3:1]};
            SHR1:    y_o = {1'b1, a_i[3:1]};
            ASL:     y_o = {a_i[2:0], 1'b0};
            ASR:     y_o = {a_i[3], a_i[3:1]};
            ROL:     y_o = {a_i[2:0], a_i[3]};
            ROR:     y_o = {a_i[0], a_i[3:1]};
            default: y_o = 4'b0000;
        endcase
    end

endmodule : shift_step_unit

// File: rtl/shift_sequencer.sv
// Runs a whole N-step shift operation as one-bit shifts, one per clock.
// Latency: Steps clocks of SHIFT after acceptance, then one DONE cycle.
// Backpressure: Start is only taken in IDLE/DONE; ignored while Busy.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [3:0]       Din,
    input  logic [2:0]       Mode,
    input  logic [CNT_W-1:0] Steps,
    input  logic             Abort,
    output logic [3:0]       R,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] StepsLeft
);

    state_e           state_q, state_d;
    logic [3:0]       r_q, r_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       step_res;

    shift_step_unit u_step (
        .a_i    (r_q),
        .mode_i (mode_q),
        .y_o    (step_res)
    );

    // State, result, mode and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= 4'b0000;
            mode_q  <= SHL0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE/DONE, step in SHIFT, abort back to IDLE
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    r_d     = Din;
                    mode_d  = Mode;
                    cnt_d   = Steps;
                    state_d = (Steps != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (Abort) begin
                    // Partial result and count are left visible
                    state_d = ST_IDLE;
                end else begin
                    r_d   = step_res;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign R         = r_q;
    assign StepsLeft = cnt_q;
    assign Busy      = (state_q == ST_SHIFT);
    assign Done      = (state_q == ST_DONE);

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed operations, monitor on Busy/Done.
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_sequencer;

    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             Start;
    logic [3:0]       Din;
    logic [2:0]       Mode;
    logic [CNT_W-1:0] Steps;
    logic             Abort;
    logic [3:0]       R;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] StepsLeft;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    // Expected {StepsLeft, R} for every Busy cycle, and expected R per Done pulse
    logic [6:0] q_busy[$];
    logic [3:0] q_done[$];

    shift_sequencer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Din       (Din),
        .Mode      (Mode),
        .Steps     (Steps),
        .Abort     (Abort),
        .R         (R),
        .Busy      (Busy),
        .Done      (Done),
        .StepsLeft (StepsLeft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare against queued expectations whenever the DUT is Busy or Done
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (Busy) begin
                if (q_busy.size() == 0) begin
                    chk("unexpected_busy", 1, 0);
                end else begin
                    logic [6:0] e;
                    e = q_busy.pop_front();
                    chk("busy_R", int'(R), int'(e[3:0]));
                    chk("busy_StepsLeft", int'(StepsLeft), int'(e[6:4]));
                end
            end
            if (Done) begin
                if (q_done.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    logic [3:0] f;
                    f = q_done.pop_front();
                    chk("done_R", int'(R), int'(f));
                    chk("done_StepsLeft", int'(StepsLeft), 0);
                    chk("done_Busy", int'(Busy), 0);
                end
            end
        end
    end

    task automatic exp_busy(input logic [3:0] r, input logic [2:0] cnt);
        q_busy.push_back({cnt, r});
    endtask

    // Present one operation for a single accepting edge
    task automatic issue(input logic [3:0] d, input logic [2:0] m, input logic [2:0] n);
        @(posedge clk); #1;
        Start = 1'b1; Din = d; Mode = m; Steps = n;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((Busy || Done) && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        if (Busy || Done) chk("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        rst = 1'b1; Start = 1'b1; Din = 4'b1111; Mode = 3'b111; Steps = 3'd5; Abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_R", int'(R), 0);
        chk("reset_Busy", int'(Busy), 0);
        chk("reset_Done", int'(Done), 0);
        chk("reset_StepsLeft", int'(StepsLeft), 0);
        rst = 1'b0; Start = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", int'({Busy, Done}), 0);

        // Rotate left
        exp_busy(4'b1011, 3'd2); exp_busy(4'b0111, 3'd1); q_done.push_back(4'b1110);
        issue(4'b1011, 3'b110, 3'd2); wait_idle();

        // Arithmetic right
        exp_busy(4'b1000, 3'd3); exp_busy(4'b1100, 3'd2); exp_busy(4'b1110, 3'd1);
        q_done.push_back(4'b1111);
        issue(4'b1000, 3'b101, 3'd3); wait_idle();

        // Fill-1 left
        exp_busy(4'b0000, 3'd4); exp_busy(4'b0001, 3'd3); exp_busy(4'b0011, 3'd2);
        exp_busy(4'b0111, 3'd1); q_done.push_back(4'b1111);
        issue(4'b0000, 3'b001, 3'd4); wait_idle();

        // Rotate right full cycle, then back-to-back start in DONE
        exp_busy(4'b1011, 3'd4); exp_busy(4'b1101, 3'd3); exp_busy(4'b1110, 3'd2);
        exp_busy(4'b0111, 3'd1); q_done.push_back(4'b1011);
        exp_busy(4'b0110, 3'd1); q_done.push_back(4'b0011);
        issue(4'b1011, 3'b111, 3'd4);
        begin
            int k;
            k = 0;
            while (!Done && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            if (!Done) chk("b2b_wait_done", 1, 0);
        end
        Start = 1'b1; Din = 4'b0110; Mode = 3'b010; Steps = 3'd1;
        @(posedge clk); #1;
        Start = 1'b0;
        chk("b2b_busy_after_done", int'(Busy), 1);
        wait_idle();

        // Zero steps: Abort in IDLE must have no effect either
        Abort = 1'b1;
        q_done.push_back(4'b0101);
        issue(4'b0101, 3'b000, 3'd0);
        Abort = 1'b0;
        wait_idle();

        // Arithmetic left, fill-1 right, fill-0 left
        exp_busy(4'b0111, 3'd1); q_done.push_back(4'b1110);
        issue(4'b0111, 3'b100, 3'd1); wait_idle();
        exp_busy(4'b0000, 3'd2); exp_busy(4'b1000, 3'd1); q_done.push_back(4'b1100);
        issue(4'b0000, 3'b011, 3'd2); wait_idle();
        exp_busy(4'b0011, 3'd3); exp_busy(4'b0110, 3'd2); exp_busy(4'b1100, 3'd1);
        q_done.push_back(4'b1000);
        issue(4'b0011, 3'b000, 3'd3); wait_idle();

        // Abort after the second shift
        exp_busy(4'b1011, 3'd4); exp_busy(4'b1101, 3'd3); exp_busy(4'b1110, 3'd2);
        issue(4'b1011, 3'b111, 3'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        Abort = 1'b1;
        @(posedge clk); #1;
        Abort = 1'b0;
        @(negedge clk);
        chk("abort_R", int'(R), 4'b1110);
        chk("abort_StepsLeft", int'(StepsLeft), 2);
        chk("abort_Busy", int'(Busy), 0);
        chk("abort_Done", int'(Done), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("busy_queue_drained", q_busy.size(), 0);
        chk("done_queue_drained", q_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_sequencer
